// File: rtl/tg_pkg.sv
// rtl/tg_pkg.sv - Shared mode encodings, FSM state type and LFSR tap table for tg_stream_gen
package tg_pkg;

  localparam logic [1:0] TG_MODE_RAMP  = 2'd0;
  localparam logic [1:0] TG_MODE_LFSR  = 2'd1;
  localparam logic [1:0] TG_MODE_CONST = 2'd2;

  typedef enum logic {TG_IDLE = 1'b0, TG_SEND = 1'b1} tg_state_e;

  // Right-shifting Galois feedback masks; the MSB of each mask is set so a non-zero state never reaches zero.
  function automatic logic [31:0] tg_lfsr_taps(input int width);
    case (width)
      2:  return 32'h0000_0003;
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0000_0003;
    endcase
  endfunction

endpackage

// File: rtl/tg_channel.sv
// rtl/tg_channel.sv - One traffic channel: packet FSM, word counter, payload generator, packet counter (LFSR gated by TG_LFSR_EN)
module tg_channel
  import tg_pkg::*;
#(
  parameter int                 DATA_W    = 14,
  parameter int                 LEN_W     = 16,
  parameter int                 CH_IDX    = 0,
  parameter logic [DATA_W-1:0]  CONST_VAL = '0
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              extenable,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  input  logic              tready,
  output logic [15:0]       pkt_count
);

  localparam logic [DATA_W-1:0] RAMP_INIT = DATA_W'(CH_IDX);

  tg_state_e         state_q, state_nxt;
  logic [1:0]        mode_q, mode_nxt, mode_in_eff;
  logic [LEN_W-1:0]  len_q, len_nxt, cnt_q, cnt_nxt;
  logic [DATA_W-1:0] ramp_q, ramp_nxt, tdata_d;
  logic              xfer, start, tvalid_d, tlast_d;

`ifdef TG_LFSR_EN
  localparam logic [31:0]       TAPS      = tg_lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] LFSR_SEED = (DATA_W'(CH_IDX + 1) == '0) ? DATA_W'(1) : DATA_W'(CH_IDX + 1);
  logic [DATA_W-1:0] lfsr_q, lfsr_nxt;
`endif

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= TG_IDLE;
      mode_q    <= TG_MODE_RAMP;
      len_q     <= LEN_W'(1);
      cnt_q     <= '0;
      ramp_q    <= RAMP_INIT;
      tvalid    <= 1'b0;
      tdata     <= '0;
      tlast     <= 1'b0;
      pkt_count <= '0;
`ifdef TG_LFSR_EN
      lfsr_q    <= LFSR_SEED;
`endif
    end else begin
      state_q   <= state_nxt;
      mode_q    <= mode_nxt;
      len_q     <= len_nxt;
      cnt_q     <= cnt_nxt;
      ramp_q    <= ramp_nxt;
      tvalid    <= tvalid_d;
      tdata     <= tdata_d;
      tlast     <= tlast_d;
      if (xfer && tlast)
        pkt_count <= pkt_count + 16'd1;
`ifdef TG_LFSR_EN
      lfsr_q    <= lfsr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TG_IDLE: if (extenable) state_nxt = TG_SEND;
      TG_SEND: if (xfer && tlast && !extenable) state_nxt = TG_IDLE;
      default: state_nxt = TG_IDLE;
    endcase
  end

  // Outputs are registered, so everything below computes the value the next cycle presents.
  always_comb begin
    xfer = tvalid & tready;
    start = extenable && ((state_q == TG_IDLE) || (xfer && tlast));
`ifdef TG_LFSR_EN
    mode_in_eff = (mode == TG_MODE_LFSR || mode == TG_MODE_CONST) ? mode : TG_MODE_RAMP;
`else
    mode_in_eff = (mode == TG_MODE_CONST) ? TG_MODE_CONST : TG_MODE_RAMP;
`endif
    mode_nxt = start ? mode_in_eff : mode_q;
    len_nxt  = start ? ((pkt_len == '0) ? LEN_W'(1) : pkt_len) : len_q;
    cnt_nxt  = start ? '0 : (xfer ? cnt_q + LEN_W'(1) : cnt_q);
    ramp_nxt = (xfer && mode_q == TG_MODE_RAMP) ? ramp_q + DATA_W'(1) : ramp_q;
`ifdef TG_LFSR_EN
    lfsr_nxt = lfsr_q;
    if (xfer && mode_q == TG_MODE_LFSR)
      lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS[DATA_W-1:0] : '0);
`endif
    tvalid_d = (state_nxt == TG_SEND);
    tlast_d  = tvalid_d && (cnt_nxt == len_nxt - LEN_W'(1));
    tdata_d  = '0;
    if (tvalid_d) begin
      case (mode_nxt)
        TG_MODE_CONST: tdata_d = CONST_VAL;
`ifdef TG_LFSR_EN
        TG_MODE_LFSR:  tdata_d = lfsr_nxt;
`endif
        default:       tdata_d = ramp_nxt;
      endcase
    end
  end

endmodule

// File: rtl/tg_stream_gen.sv
// rtl/tg_stream_gen.sv - Multi-channel AXI-Stream traffic generator top (LFSR payload enabled by TG_LFSR_EN)
module tg_stream_gen
  import tg_pkg::*;
#(
  parameter int                CHANNELS  = 8,
  parameter int                DATA_W    = 14,
  parameter int                LEN_W     = 16,
  parameter logic [DATA_W-1:0] CONST_VAL = '0
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic                       extenable,
  input  logic [1:0]                 mode,
  input  logic [LEN_W-1:0]           pkt_len,
  output logic [CHANNELS-1:0]        M_AXIS_TVALID,
  output logic [CHANNELS*DATA_W-1:0] M_AXIS_TDATA,
  output logic [CHANNELS-1:0]        M_AXIS_TLAST,
  input  logic [CHANNELS-1:0]        M_AXIS_TREADY,
  output logic [CHANNELS*16-1:0]     pkt_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tg_channel #(
      .DATA_W    (DATA_W),
      .LEN_W     (LEN_W),
      .CH_IDX    (i),
      .CONST_VAL (CONST_VAL)
    ) u_ch (
      .aclk      (aclk),
      .reset     (reset),
      .extenable (extenable),
      .mode      (mode),
      .pkt_len   (pkt_len),
      .tvalid    (M_AXIS_TVALID[i]),
      .tdata     (M_AXIS_TDATA[i*DATA_W +: DATA_W]),
      .tlast     (M_AXIS_TLAST[i]),
      .tready    (M_AXIS_TREADY[i]),
      .pkt_count (pkt_count[i*16 +: 16])
    );
  end

endmodule

// File: doc/tg_stream_gen.md
# tg_stream_gen

Parametrised multi-channel AXI-Stream traffic generator, the successor to the fixed 14-bit per-channel generator array. Drives CHANNELS independent master streams of configurable width, framed into packets with TLAST and filled with ramp, LFSR or constant payload. Sits at the receiver-side stream inputs as a test and bring-up source, gated by a shared external enable.

## Interface
- CHANNELS, 8, number of independent output streams
- DATA_W, 14, payload width per stream (2..32)
- LEN_W, 16, width of the packet-length input
- CONST_VAL, 0, payload word for constant mode (DATA_W bits)
- aclk  in  1  single clock domain for all logic
- reset  in  1  synchronous, active-high reset
- extenable  in  1  global run enable, sampled every aclk edge
- mode  in  2  payload select: 0 ramp, 1 LFSR, 2 constant, 3 reserved (treated as ramp)
- pkt_len  in  LEN_W  words per packet; 0 treated as 1
- M_AXIS_TVALID  out  CHANNELS  per-channel valid
- M_AXIS_TDATA  out  CHANNELS*DATA_W  flat bus; channel i occupies bits [i*DATA_W +: DATA_W]
- M_AXIS_TLAST  out  CHANNELS  per-channel end of packet
- M_AXIS_TREADY  in  CHANNELS  per-channel ready
- pkt_count  out  CHANNELS*16  per-channel count of completed packets, wraps at 65535 -> 0

## Operation
- Each channel runs an independent two-state FSM: IDLE and SEND.
- IDLE: TVALID=0. If extenable=1, latch mode and pkt_len into the channel, clear the word counter, go to SEND.
- SEND: TVALID=1. A word transfers on TVALID&TREADY. The word counter increments per transfer. TLAST=1 while counter == latched_len-1.
- On a transfer with TLAST=1: pkt_count increments. If extenable=1, re-latch mode/pkt_len and stay in SEND (back-to-back packets, no bubble). Otherwise go to IDLE.
- extenable falling mid-packet: the current packet completes in full; no truncation.
- mode/pkt_len changes mid-packet: ignored until the next packet start.
- Ramp: first word after reset is channel index i (mod 2^DATA_W); +1 per transfer; wraps 2^DATA_W-1 -> 0. Ramp state persists across packets and IDLE periods.
- LFSR: DATA_W-bit Galois LFSR, taps from package table; seed = i+1 (never zero); advances once per transfer; state persists across packets.
- Constant: TDATA = CONST_VAL on every word.
- Channels never stall each other; TREADY of channel j has no effect on channel k.

## Timing
- Reset values: TVALID=0, TDATA=0, TLAST=0, pkt_count=0, FSM=IDLE, ramp=i, LFSR=i+1.
- extenable 0->1 at edge n: TVALID=1 from edge n+1. First TDATA valid on the same cycle.
- All outputs registered; no combinational path from TREADY or extenable to any output.
- TDATA/TLAST held stable while TVALID=1 and TREADY=0 (AXI-Stream compliant).
- Throughput: one word per cycle per channel with TREADY held high, including across packet boundaries.
- reset asserted mid-packet: all outputs take reset values on the next edge; the partial packet is abandoned and pkt_count is not incremented.

## Configuration
- TG_LFSR_EN defined: LFSR state and mode 1 are implemented as above.
- TG_LFSR_EN undefined: no LFSR logic is synthesised; mode 1 behaves exactly as mode 0 (ramp).

## Structure
- Package tg_pkg: mode encoding constants (TG_MODE_RAMP, TG_MODE_LFSR, TG_MODE_CONST), FSM state typedef, LFSR tap table indexed by DATA_W.
- Sub-module tg_channel: one FSM, word counter, payload generator and packet counter; top level is a generate loop over CHANNELS plus bus flattening.

## Test plan
- Ramp, CHANNELS=2, DATA_W=14, pkt_len=4, TREADY=1, extenable=1 -> ch0 words 0,1,2,3 (TLAST on 3), then 4..7; ch1 words start at 1; TVALID one cycle after enable.
- Wrap: DATA_W=4, ramp, pkt_len=20 -> ch0 word sequence 0..15, 0..3, TLAST on the 20th word, pkt_count=1.
- Backpressure: TREADY toggling 1,0,0,1 on ch0 only -> ch0 TDATA/TLAST stable across stalled cycles, ch1 unaffected at full rate.
- Enable drop: pkt_len=8, deassert extenable after word 3 -> words 4..7 still sent, TLAST on word 7, then TVALID=0 and pkt_count=1.
- Reset mid-packet after word 2 of pkt_len=5 -> next cycle TVALID=0, pkt_count=0; after re-enable ch0 restarts at 0.
- LFSR (TG_LFSR_EN defined), mode=1 -> sequence matches reference model seeded i+1, never 0; with macro undefined, mode=1 output equals ramp.
